// File: rtl/pattern_gen_pkg.sv
// Shared encodings and helpers for the parameterised pattern generator.
// Constants are held at the maximum supported width (16) and truncated by users.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_EVENODD = 2'b00,
    MODE_GRAY    = 2'b01,
    MODE_WALK1   = 2'b10,
    MODE_JOHNSON = 2'b11
  } pg_mode_e;

  localparam int unsigned MAX_WIDTH = 16;

  localparam logic [MAX_WIDTH-1:0] START_EVENODD = 16'd0;
  localparam logic [MAX_WIDTH-1:0] START_GRAY    = 16'd0;
  localparam logic [MAX_WIDTH-1:0] START_WALK1   = 16'd1;
  localparam logic [MAX_WIDTH-1:0] START_JOHNSON = 16'd0;

  function automatic logic [MAX_WIDTH-1:0] start_value(input pg_mode_e m);
    logic [MAX_WIDTH-1:0] v;
    v = START_EVENODD;
    case (m)
      MODE_EVENODD: v = START_EVENODD;
      MODE_GRAY:    v = START_GRAY;
      MODE_WALK1:   v = START_WALK1;
      MODE_JOHNSON: v = START_JOHNSON;
      default:      v = START_EVENODD;
    endcase
    return v;
  endfunction

  // Zero-extended inputs convert correctly because the extra top bits are zero.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] r;
    r[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ g[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/pg_next.sv
// Combinational next-value function: given the current mode/sel and the
// registered pattern y and Gray binary counter b, produce the advanced values.
module pg_next
  import pattern_gen_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STEP  = 2
) (
  input  pg_mode_e         mode,
  input  logic             sel,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_next,
  output logic [WIDTH-1:0] b_next
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES_W = '1;

  always_comb begin
    y_next = y;
    b_next = b;
    case (mode)
      MODE_EVENODD: begin
        // The odd sequence needs an escape from 0 into 1 and from all-ones back to 0.
        if (!sel && (y == '0)) begin
          y_next = ONE_W;
        end else if (!sel && (y == ONES_W)) begin
          y_next = '0;
        end else begin
          y_next = y + STEP_W;
        end
      end
      MODE_GRAY: begin
        b_next = b + ONE_W;
        y_next = b_next ^ (b_next >> 1);
      end
      MODE_WALK1: begin
        if (y == '0) begin
          y_next = ONE_W;
        end else begin
          y_next = {y[WIDTH-2:0], y[WIDTH-1]};
        end
      end
      MODE_JOHNSON: begin
        y_next = {y[WIDTH-2:0], ~y[WIDTH-1]};
      end
      default: begin
        y_next = y;
        b_next = b;
      end
    endcase
  end

endmodule

// File: rtl/pattern_gen_param.sv
// Parameterised pattern generator: even/odd counter, Gray, walking-one and
// Johnson sequences with seed load, restart on mode/sel change, and wrap pulse.
module pattern_gen_param
  import pattern_gen_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STEP  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sel,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] y,
  output logic             valid,
  output logic             wrap
);

  pg_mode_e         mode_in;
  pg_mode_e         mode_q;
  logic             sel_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] y_next;
  logic [WIDTH-1:0] b_next;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] seed_bin;
  logic             restart;

  assign mode_in   = pg_mode_e'(mode);
  assign start_val = WIDTH'(start_value(mode_in));
  assign seed_bin  = WIDTH'(gray2bin(MAX_WIDTH'(seed)));

  // sel only matters in the even/odd mode, so it only triggers a restart there.
  assign restart = en && ((mode_in != mode_q) ||
                          ((mode_in == MODE_EVENODD) && (sel != sel_q)));

  pg_next #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_next (
    .mode   (mode_in),
    .sel    (sel),
    .y      (y),
    .b      (b_q),
    .y_next (y_next),
    .b_next (b_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y      <= '0;
      b_q    <= '0;
      valid  <= 1'b0;
      wrap   <= 1'b0;
      mode_q <= MODE_EVENODD;
      sel_q  <= 1'b0;
    end else begin
      mode_q <= mode_in;
      sel_q  <= sel;
      valid  <= en;
      wrap   <= 1'b0;
      if (load) begin
        y   <= seed;
        b_q <= seed_bin;
      end else if (restart) begin
        y   <= start_val;
        b_q <= '0;
      end else if (en) begin
        y    <= y_next;
        b_q  <= b_next;
        wrap <= (y_next == start_val);
      end
    end
  end

endmodule

// File: tb/tb_pattern_gen_param.sv
// Directed bench for pattern_gen_param (WIDTH=4, STEP=2) with an arithmetic
// reference model compared every cycle plus hand-computed literal sequences.
module tb_pattern_gen_param;

  localparam int WIDTH = 4;
  localparam int STEP  = 2;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic             sel;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] y;
  logic             valid;
  logic             wrap;

  int pass_cnt;
  int total_cnt;

  // Reference model state
  int m_y;
  int m_b;
  int m_mode;
  int m_sel;
  int m_valid;
  int m_wrap;

  pattern_gen_param #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .sel   (sel),
    .load  (load),
    .seed  (seed),
    .y     (y),
    .valid (valid),
    .wrap  (wrap)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
  endtask

  function automatic int start_of(input int md);
    return (md == 2) ? 1 : 0;
  endfunction

  function automatic int to_bin(input int g);
    return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & MASK;
  endfunction

  task automatic model_reset();
    m_y = 0; m_b = 0; m_mode = 0; m_sel = 0; m_valid = 0; m_wrap = 0;
  endtask

  task automatic model_edge(input int e, input int md, input int s, input int ld, input int sd);
    bit rs;
    rs = (e != 0) && ((md != m_mode) || (md == 0 && s != m_sel));
    m_wrap = 0;
    if (ld != 0) begin
      m_y = sd;
      m_b = to_bin(sd);
    end else if (rs) begin
      m_y = start_of(md);
      m_b = 0;
    end else if (e != 0) begin
      case (md)
        0: begin
          if (s == 0 && m_y == 0) m_y = 1;
          else if (s == 0 && m_y == MASK) m_y = 0;
          else m_y = (m_y + STEP) % (MASK + 1);
        end
        1: begin
          m_b = (m_b + 1) % (MASK + 1);
          m_y = m_b ^ (m_b / 2);
        end
        2: m_y = (m_y == 0) ? 1 : ((m_y * 2) % (MASK + 1)) + (m_y / (1 << (WIDTH - 1)));
        default: m_y = ((m_y * 2) % (MASK + 1)) + ((m_y >= (1 << (WIDTH - 1))) ? 0 : 1);
      endcase
      m_wrap = (m_y == start_of(md)) ? 1 : 0;
    end
    m_mode = md;
    m_sel = s;
    m_valid = e;
  endtask

  task automatic compare_all();
    check("model_y", int'(y), m_y);
    check("model_valid", int'(valid), m_valid);
    check("model_wrap", int'(wrap), m_wrap);
  endtask

  // Driver: apply inputs, take one edge, advance model, compare #1 later.
  task automatic step(input int e, input int md, input int s, input int ld, input int sd);
    en   = e[0];
    mode = md[1:0];
    sel  = s[0];
    load = ld[0];
    seed = sd[WIDTH-1:0];
    @(posedge clk);
    model_edge(e, md, s, ld, sd);
    #1;
    compare_all();
  endtask

  int even_exp[8] = '{2, 4, 6, 8, 10, 12, 14, 0};
  int odd_exp[9]  = '{1, 3, 5, 7, 9, 11, 13, 15, 0};
  int gray_exp[16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
  int walk_exp[4] = '{2, 4, 8, 1};
  int john_exp[8] = '{1, 3, 7, 15, 14, 12, 8, 0};

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    en = 1'b0; mode = 2'b00; sel = 1'b0; load = 1'b0; seed = '0;
    model_reset();
    #2;
    check("reset_y", int'(y), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_wrap", int'(wrap), 0);
    #10 rst_n = 1'b1;

    // Even counting from reset: restart to 0, then 2..14, 0 with wrap.
    step(1, 0, 1, 0, 0);
    check("even_restart_y", int'(y), 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1, 0, 0);
      check("even_y", int'(y), even_exp[i]);
      check("even_wrap", int'(wrap), (i == 7) ? 1 : 0);
    end

    // Odd counting, then sel toggle at y=7 restarts without wrap.
    step(1, 0, 0, 0, 0);
    check("odd_restart_y", int'(y), 0);
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 0, 0, 0);
      check("odd_y", int'(y), odd_exp[i]);
      check("odd_wrap", int'(wrap), (i == 8) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    check("odd_at_7", int'(y), 7);
    step(1, 0, 1, 0, 0);
    check("sel_toggle_y", int'(y), 0);
    check("sel_toggle_wrap", int'(wrap), 0);

    // Gray full cycle, then seed load 6 and advance to 7.
    step(1, 1, 1, 0, 0);
    check("gray_restart_y", int'(y), 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 1, 0, 0);
      check("gray_y", int'(y), gray_exp[i]);
      check("gray_wrap", int'(wrap), (i == 15) ? 1 : 0);
    end
    step(1, 1, 1, 1, 6);
    check("gray_load_y", int'(y), 6);
    step(1, 1, 1, 0, 0);
    check("gray_after_load_y", int'(y), 7);

    // Walking one and Johnson.
    step(1, 2, 1, 0, 0);
    check("walk_restart_y", int'(y), 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 2, 1, 0, 0);
      check("walk_y", int'(y), walk_exp[i]);
      check("walk_wrap", int'(wrap), (i == 3) ? 1 : 0);
    end
    step(1, 3, 1, 0, 0);
    check("john_restart_y", int'(y), 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 3, 1, 0, 0);
      check("john_y", int'(y), john_exp[i]);
      check("john_wrap", int'(wrap), (i == 7) ? 1 : 0);
    end

    // Load wins over a simultaneous mode change.
    step(1, 0, 1, 1, 9);
    check("load_modechg_y", int'(y), 9);
    step(1, 0, 1, 0, 0);
    check("after_load_even_y", int'(y), 11);

    // Walking one recovers from a loaded zero.
    step(1, 2, 0, 1, 0);
    check("walk_load0_y", int'(y), 0);
    step(1, 2, 0, 0, 0);
    check("walk_from0_y", int'(y), 1);

    // Hold: load 4 with en=0, advance to 6, then hold.
    step(0, 0, 1, 1, 4);
    check("hold_load_y", int'(y), 4);
    check("hold_load_valid", int'(valid), 0);
    step(1, 0, 1, 0, 0);
    check("hold_adv_y", int'(y), 6);
    step(0, 0, 1, 0, 0);
    check("hold_y", int'(y), 6);
    check("hold_valid", int'(valid), 0);
    step(0, 0, 1, 0, 0);
    check("hold2_y", int'(y), 6);

    // Asynchronous reset pulse between edges.
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_y", int'(y), 0);
    check("async_rst_valid", int'(valid), 0);
    compare_all();
    #1 rst_n = 1'b1;
    step(1, 0, 0, 0, 0);
    check("post_rst_odd_y", int'(y), 1);

    // Johnson from an arbitrary seed.
    step(1, 3, 0, 1, 5);
    step(1, 3, 0, 0, 0);
    check("john_seed_y", int'(y), 11);

    // sel is ignored in Gray; mode/sel register even while en=0.
    step(1, 1, 0, 0, 0);
    check("gray_restart2_y", int'(y), 0);
    step(1, 1, 1, 0, 0);
    check("gray_sel_ignored_y", int'(y), 1);
    step(0, 0, 0, 0, 0);
    check("idle_modechg_y", int'(y), 1);
    step(1, 0, 0, 0, 0);
    check("no_restart_after_idle_y", int'(y), 3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pattern_gen_param.md
PATTERN_GEN_PARAM -- requirements
Module: pattern_gen_param

Interface
REQ-001 SHALL have parameter WIDTH, default 4: pattern width in bits, legal range 3..16.
REQ-002 SHALL have parameter STEP, default 2: increment for the even/odd sequences, legal range 1..2^(WIDTH-1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port en, input, 1 bit: advance enable.
REQ-006 SHALL have port mode, input, 2 bits: 00 even/odd, 01 Gray, 10 walking-one, 11 Johnson.
REQ-007 SHALL have port sel, input, 1 bit: in mode 00, 1 selects the even sequence and 0 the odd sequence; ignored in other modes.
REQ-008 SHALL have port load, input, 1 bit: synchronous seed load.
REQ-009 SHALL have port seed, input, WIDTH bits: value loaded by load.
REQ-010 SHALL have port y, output, WIDTH bits: registered pattern.
REQ-011 SHALL have port valid, output, 1 bit: registered copy of en.
REQ-012 SHALL have port wrap, output, 1 bit: single-cycle pulse when the sequence returns to its start value.

Function
REQ-013 SHALL give each mode a start value: 00 is 0; 01 is Gray(0)=0; 10 is 1; 11 is 0.
REQ-014 SHALL apply this per-cycle priority: load, then restart, then advance, then hold.
REQ-015 SHALL set y to seed on the next edge when load=1, regardless of en; in mode 01 the internal binary counter SHALL load the Gray-to-binary conversion of seed.
REQ-016 SHALL restart when en=1 and either mode differs from the registered mode or (mode=00 and sel differs from the registered sel): y goes to the start value, and registered mode and sel update on the same edge.
REQ-017 SHALL register mode and sel on every edge, not only when en=1.
REQ-018 SHALL advance in mode 00 with sel=1 as y+STEP modulo 2^WIDTH.
REQ-019 SHALL advance in mode 00 with sel=0 as follows: y=0 gives 1; y=all-ones gives 0; otherwise y+STEP modulo 2^WIDTH.
REQ-020 SHALL advance in mode 01 by incrementing the internal binary counter b modulo 2^WIDTH, with y = b XOR (b>>1).
REQ-021 SHALL advance in mode 10 by rotating y left by 1; a y of 0 after a load SHALL become 1.
REQ-022 SHALL advance in mode 11 as Johnson: y = {y[WIDTH-2:0], ~y[WIDTH-1]}, period 2*WIDTH.
REQ-023 SHALL hold y when en=0; no X is ever driven.
REQ-024 SHALL assert wrap for one cycle, aligned with y, when an advance (not a load or restart) produces the start value.
REQ-025 SHALL produce y exactly one clock after the qualifying input edge (latency 1).

Reset
REQ-026 SHALL force y=0, b=0, valid=0, wrap=0, registered mode=00 and registered sel=0 while rst_n=0, independent of clk.
REQ-027 SHALL resume from the reset values on the first rising clk edge after rst_n deasserts; an assertion mid-sequence discards all state.

Structure
REQ-028 SHALL place the mode encodings (MODE_EVENODD, MODE_GRAY, MODE_WALK1, MODE_JOHNSON) and start-value constants in shared package pattern_gen_pkg.
REQ-029 SHALL instantiate exactly one sub-module, pg_next, a combinational next-value function of mode, sel and y/b; state registers stay in pattern_gen_param.

Verification (WIDTH=4, STEP=2)
REQ-030 SHALL cover even counting: mode=00, sel=1, en=1 from reset gives y=0,2,4,...,14,0, with wrap high on the 14->0 edge only.
REQ-031 SHALL cover odd counting: mode=00, sel=0 gives y=0,1,3,5,...,15,0 with wrap at 15->0; toggling sel to 1 at y=7 gives y=0 on the next edge and no wrap.
REQ-032 SHALL cover Gray: mode=01 gives y=0,1,3,2,6,7,5,4,12,... with wrap after 8 (y=8->0, b=15->0); load with seed=6 gives y=6, then 7.
REQ-033 SHALL cover walking-one and Johnson: mode=10 gives 1,2,4,8,1 with wrap; mode=11 gives 0,1,3,7,15,14,12,8,0; load=1 together with a mode change gives y=seed.
REQ-034 SHALL cover hold and reset: en=0 at y=6 holds 6 and drops valid after 1 cycle; rst_n pulsed low between edges gives y=0 and valid=0 immediately.
